// File: rtl/clock_display_pkg.sv
// Shared constants for the clock display scanner: active-low segment codes,
// digit slot numbers and the snapshot record of the displayed time.
package clock_display_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_E     = 8'h86;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Digit slots, rightmost first; the display reads HH-MM-SS.
   localparam logic [2:0] IDX_SEC_ONES  = 3'd0;
   localparam logic [2:0] IDX_SEC_TENS  = 3'd1;
   localparam logic [2:0] SEP_IDX_A     = 3'd2;
   localparam logic [2:0] IDX_MIN_ONES  = 3'd3;
   localparam logic [2:0] IDX_MIN_TENS  = 3'd4;
   localparam logic [2:0] SEP_IDX_B     = 3'd5;
   localparam logic [2:0] IDX_HOUR_ONES = 3'd6;
   localparam logic [2:0] IDX_HOUR_TENS = 3'd7;

   typedef struct packed {
      logic [7:0] hour;
      logic [7:0] minute;
      logic [7:0] second;
   } bcd_time_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-decimal
// nibbles show 'E' so corrupt input is visible on the display.
module seg7_decode
   import clock_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] seg
);

   always_comb begin
      case (nibble)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         default: seg = SEG_E;
      endcase
   end

endmodule

// File: rtl/clock_display_scan.sv
// Scans the BCD time onto an 8-digit common-anode display as HH-MM-SS,
// snapshotting the inputs once per frame so a frame never tears.
module clock_display_scan
   import clock_display_pkg::*;
#(
   parameter int SCAN_DIV = 16,
   parameter bit LZB      = 1'b1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] hour,
   input  logic [7:0] minute,
   input  logic [7:0] second,
   output logic [7:0] an,
   output logic [7:0] seg,
   output logic       frame_start
);

   localparam int              PC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_DIV - 1);

   logic [PC_W-1:0] pc;
   logic [2:0]      idx;
   bcd_time_t       shadow;
   logic [3:0]      nibble;
   logic [7:0]      decoded;
   logic [7:0]      digit_seg;
   logic            digit_end;
   logic            frame_end;

   assign digit_end = (pc == PC_LAST);
   assign frame_end = digit_end && (idx == IDX_HOUR_TENS);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc  <= '0;
         idx <= IDX_SEC_ONES;
      end else begin
         pc <= digit_end ? '0 : pc + PC_W'(1);
         if (digit_end)
            idx <= idx + 3'd1;
      end
   end

   // Loading on the same edge as idx 7->0 means digit 0 already shows new data.
   always_ff @(posedge clk) begin
      if (rst)
         shadow <= '0;
      else if (frame_end)
         shadow <= {hour, minute, second};
   end

   always_comb begin
      case (idx)
         IDX_SEC_ONES:  nibble = shadow.second[3:0];
         IDX_SEC_TENS:  nibble = shadow.second[7:4];
         IDX_MIN_ONES:  nibble = shadow.minute[3:0];
         IDX_MIN_TENS:  nibble = shadow.minute[7:4];
         IDX_HOUR_ONES: nibble = shadow.hour[3:0];
         IDX_HOUR_TENS: nibble = shadow.hour[7:4];
         default:       nibble = 4'h0;
      endcase
   end

   seg7_decode u_decode (
      .nibble (nibble),
      .seg    (decoded)
   );

   // Separators blink with the seconds LSB; dp is never lit.
   always_comb begin
      digit_seg = decoded;
      if (idx == SEP_IDX_A || idx == SEP_IDX_B)
         digit_seg = shadow.second[0] ? SEG_BLANK : SEG_DASH;
      else if (LZB && idx == IDX_HOUR_TENS && shadow.hour[7:4] == 4'h0)
         digit_seg = SEG_BLANK;
      digit_seg[7] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= 8'hFF;
         seg <= SEG_BLANK;
      end else begin
         an  <= ~(8'h01 << idx);
         seg <= digit_seg;
      end
   end

   assign frame_start = !rst && (pc == '0) && (idx == IDX_SEC_ONES);

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: two instances (LZB on/off) checked cycle by
// cycle against a frame-timing model built from the display rules.
module tb_clock_display_scan;

   localparam int SD    = 4;
   localparam int FRAME = 8 * SD;

   localparam logic [7:0] SEG_TAB [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h86, 8'h86, 8'h86, 8'h86, 8'h86, 8'h86};
   localparam logic [7:0] AN_TAB [8] = '{
      8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   localparam logic [7:0] NF_SEG [8] = '{
      8'h80, 8'h92, 8'hBF, 8'h90, 8'h92, 8'hBF, 8'hB0, 8'hA4};
   localparam logic [7:0] ZERO_SEG [8] = '{
      8'hC0, 8'hC0, 8'hBF, 8'hC0, 8'hC0, 8'hBF, 8'hC0, 8'hFF};

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic [7:0]  hour   = '0;
   logic [7:0]  minute = '0;
   logic [7:0]  second = '0;
   logic [7:0]  an1, seg1, an0, seg0;
   logic        fs1, fs0;
   logic [33:0] obs;

   int          total  = 0;
   int          passes = 0;

   // Model state: m_t counts clock edges since reset release.
   int          m_t = 0;
   logic [23:0] m_shadow = '0;
   logic [23:0] m_prev_shadow = '0;

   assign obs = {an1, seg1, fs1, an0, seg0, fs0};

   always #5 clk = ~clk;

   clock_display_scan #(.SCAN_DIV(SD), .LZB(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .hour        (hour),
      .minute      (minute),
      .second      (second),
      .an          (an1),
      .seg         (seg1),
      .frame_start (fs1)
   );

   clock_display_scan #(.SCAN_DIV(SD), .LZB(1'b0)) dut_nolzb (
      .clk         (clk),
      .rst         (rst),
      .hour        (hour),
      .minute      (minute),
      .second      (second),
      .an          (an0),
      .seg         (seg0),
      .frame_start (fs0)
   );

   function automatic logic [7:0] ref_seg(int d, logic [23:0] s, bit lzb);
      int h  = s[23:16];
      int mi = s[15:8];
      int sc = s[7:0];
      case (d)
         0:       return SEG_TAB[sc % 16];
         1:       return SEG_TAB[sc / 16];
         2, 5:    return (sc % 2 == 0) ? 8'hBF : 8'hFF;
         3:       return SEG_TAB[mi % 16];
         4:       return SEG_TAB[mi / 16];
         6:       return SEG_TAB[h % 16];
         7:       return (lzb && h / 16 == 0) ? 8'hFF : SEG_TAB[h / 16];
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [33:0] exp_vec();
      logic [7:0] a;
      logic       f;
      int         d;
      if (rst)
         return {8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0};
      if (m_t == 0)
         return {8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1};
      d    = ((m_t - 1) / SD) % 8;
      a    = 8'hFF;
      a[d] = 1'b0;
      f    = (m_t % FRAME) == 0;
      return {a, ref_seg(d, m_prev_shadow, 1'b1), f, a, ref_seg(d, m_prev_shadow, 1'b0), f};
   endfunction

   function automatic logic [7:0] rand_bcd(int max_tens);
      if ($urandom_range(0, 15) == 0)
         return 8'($urandom_range(0, 255));
      return {4'($urandom_range(0, max_tens)), 4'($urandom_range(0, 9))};
   endfunction

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         m_t           = 0;
         m_shadow      = '0;
         m_prev_shadow = '0;
      end else begin
         m_prev_shadow = m_shadow;
         if (m_t % FRAME == FRAME - 1)
            m_shadow = {hour, minute, second};
         m_t++;
      end
      @(negedge clk);
   endtask

   // Advance until digit 0 of a frame built from 'target' is on the display.
   task automatic run_to_frame(input logic [23:0] target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         if (!rst && m_t % FRAME == 1 && m_prev_shadow == target) begin
            ok = 1'b1;
            break;
         end
         advance();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         advance();
         total++;
         if (obs !== {8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0})
            $display("FAIL reset_hold: got %h expected %h", obs, {8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0});
         else passes++;
      end
      rst = 1'b0;
      #1;
      total++;
      if ({an1, seg1, fs1} !== {8'hFF, 8'hFF, 1'b1})
         $display("FAIL reset_cycle1: got %h expected %h", {an1, seg1, fs1}, {8'hFF, 8'hFF, 1'b1});
      else passes++;
      advance();
      total++;
      if ({an1, seg1, fs1} !== {8'hFE, 8'hC0, 1'b0})
         $display("FAIL reset_cycle2: got %h expected %h", {an1, seg1, fs1}, {8'hFE, 8'hC0, 1'b0});
      else passes++;
   endtask

   task automatic test_normal_frame();
      bit ok;
      hour = 8'h23; minute = 8'h59; second = 8'h58;
      run_to_frame(24'h235958, ok);
      if (!ok) begin
         total++;
         $display("FAIL normal_sync: frame never reached, got none required 235958");
      end
      for (int j = 0; j < FRAME; j++) begin
         total++;
         if (obs !== exp_vec())
            $display("FAIL normal_model j=%0d: got %h expected %h", j, obs, exp_vec());
         else passes++;
         total++;
         if ({an1, seg1} !== {AN_TAB[j / SD], NF_SEG[j / SD]})
            $display("FAIL normal_digit j=%0d: got %h expected %h", j, {an1, seg1}, {AN_TAB[j / SD], NF_SEG[j / SD]});
         else passes++;
         advance();
      end
   endtask

   task automatic test_odd_second_lzb();
      bit          ok;
      int          d;
      logic [15:0] lit;
      hour = 8'h05; minute = 8'h07; second = 8'h09;
      run_to_frame(24'h050709, ok);
      if (!ok) begin
         total++;
         $display("FAIL odd_sync: frame never reached, got none required 050709");
      end
      for (int j = 0; j < FRAME; j++) begin
         d = j / SD;
         total++;
         if (obs !== exp_vec())
            $display("FAIL odd_model j=%0d: got %h expected %h", j, obs, exp_vec());
         else passes++;
         if (d == 2 || d >= 5) begin
            lit = (d == 6) ? 16'h9292 : (d == 7) ? 16'hFFC0 : 16'hFFFF;
            total++;
            if ({seg1, seg0} !== lit)
               $display("FAIL odd_lzb d=%0d: got %h expected %h", d, {seg1, seg0}, lit);
            else passes++;
         end
         advance();
      end
   endtask

   task automatic test_snapshot();
      bit ok;
      hour = 8'h12; minute = 8'h34; second = 8'h10;
      run_to_frame(24'h123410, ok);
      if (!ok) begin
         total++;
         $display("FAIL snap_sync: frame never reached, got none required 123410");
      end
      for (int j = 0; j < FRAME; j++) begin
         total++;
         if (obs !== exp_vec())
            $display("FAIL snap_model j=%0d: got %h expected %h", j, obs, exp_vec());
         else passes++;
         if (j / SD == 5) begin
            total++;
            if (seg1 !== 8'hBF)
               $display("FAIL snap_old_sep j=%0d: got %h expected bf", j, seg1);
            else passes++;
         end
         if (j == 12)
            second = 8'h11;
         advance();
      end
      total++;
      if ({an1, seg1} !== {8'hFE, 8'hF9})
         $display("FAIL snap_new_frame: got %h expected fef9", {an1, seg1});
      else passes++;
   endtask

   task automatic test_invalid_bcd();
      bit ok;
      hour = 8'h11; minute = 8'h22; second = 8'h3C;
      run_to_frame(24'h11223C, ok);
      if (!ok) begin
         total++;
         $display("FAIL bcd_sync: frame never reached, got none required 11223c");
      end
      for (int j = 0; j < FRAME; j++) begin
         total++;
         if (obs !== exp_vec())
            $display("FAIL bcd_model j=%0d: got %h expected %h", j, obs, exp_vec());
         else passes++;
         if (j / SD < 2) begin
            total++;
            if (seg1 !== ((j / SD == 0) ? 8'h86 : 8'hB0))
               $display("FAIL bcd_digit j=%0d: got %h expected %h", j, seg1, (j / SD == 0) ? 8'h86 : 8'hB0);
            else passes++;
         end
         advance();
      end
   endtask

   task automatic test_mid_frame_reset();
      bit ok;
      hour = 8'h12; minute = 8'h34; second = 8'h56;
      run_to_frame(24'h123456, ok);
      if (!ok) begin
         total++;
         $display("FAIL mrst_sync: frame never reached, got none required 123456");
      end
      repeat (5 * SD) advance();
      total++;
      if (obs !== exp_vec())
         $display("FAIL mrst_pre: got %h expected %h", obs, exp_vec());
      else passes++;
      rst = 1'b1;
      advance();
      total++;
      if ({an1, seg1, fs1} !== {8'hFF, 8'hFF, 1'b0})
         $display("FAIL mrst_hold: got %h expected ffff0", {an1, seg1, fs1});
      else passes++;
      rst = 1'b0;
      #1;
      total++;
      if ({an1, fs1} !== {8'hFF, 1'b1})
         $display("FAIL mrst_cycle1: got %h expected ff1", {an1, fs1});
      else passes++;
      for (int j = 0; j < FRAME; j++) begin
         advance();
         total++;
         if (obs !== exp_vec())
            $display("FAIL mrst_model j=%0d: got %h expected %h", j, obs, exp_vec());
         else passes++;
         total++;
         if ({an1, seg1} !== {AN_TAB[j / SD], ZERO_SEG[j / SD]})
            $display("FAIL mrst_zero j=%0d: got %h expected %h", j, {an1, seg1}, {AN_TAB[j / SD], ZERO_SEG[j / SD]});
         else passes++;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 12 * FRAME; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            hour   = rand_bcd(2);
            minute = rand_bcd(5);
            second = rand_bcd(5);
         end
         rst = ($urandom_range(0, 149) == 0);
         advance();
         total++;
         if (obs !== exp_vec())
            $display("FAIL random i=%0d: got %h expected %h", i, obs, exp_vec());
         else passes++;
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_normal_frame();
      test_odd_second_lzb();
      test_snapshot();
      test_invalid_bcd();
      test_mid_frame_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Display-side consumer of the digital clock's BCD `hour`/`minute`/`second` buses. It time-multiplexes them onto the board's 8-digit common-anode 7-segment display as `HH-MM-SS`. Inputs are snapshotted once per scan frame so a frame never mixes old and new time. The block sits between the clock counters and the display pins.

## Interface
- `SCAN_DIV`, 16: clk cycles each digit stays enabled; ≥2.
- `LZB`, 1: when 1, blank the hour-tens digit if it is 0.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `hour`  in  8  BCD hour, tens in [7:4], ones in [3:0].
- `minute`  in  8  BCD minute, same layout.
- `second`  in  8  BCD second, same layout.
- `an`  out  8  digit enables, active-low, one-hot-low; bit 0 is the rightmost digit.
- `seg`  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.
- `frame_start`  out  1  high for one cycle when digit 0 of a new frame is selected.

## Operation
- Prescaler `pc` counts 0..SCAN_DIV-1, then wraps. When `pc`==SCAN_DIV-1, digit index `idx` (0..7) increments, wrapping 7→0.
- Frame wrap is `pc`==SCAN_DIV-1 and `idx`==7. On that edge, the shadow register `{hour,minute,second}` loads the inputs. All digits of a frame use only the shadow. Input changes at any other time have no visible effect until the next frame.
- Digit map by `idx`:
  - 0: second ones; 1: second tens.
  - 2: separator; 3: minute ones; 4: minute tens.
  - 5: separator; 6: hour ones; 7: hour tens.
- Nibble decode, active-low hex: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90. Nibbles A–F decode to 'E' = 86.
- Separator: dash BF when shadow second bit 0 is 0, blank FF when it is 1. The dash blinks at 0.5 Hz.
- LZB: if LZB=1 and shadow hour[7:4]==0, digit 7 is FF.
- dp is never lit, so `seg[7]` is always 1.
- `an` = ~(1<<idx), registered.
- `frame_start` = (`pc`==0 && `idx`==0), combinational from registers. It is also high in the first cycle after reset release.

## Timing
- Reset values: `pc`=0, `idx`=0, shadow=0, `an`=FF, `seg`=FF, `frame_start`=0 while `rst` is high.
- `an`/`seg` are registered from (`idx`, shadow) with a 1-cycle latency.
- In the first cycle after `rst` falls: `an`=FF, `seg`=FF. The second cycle gives `an`=FE, `seg`=C0.
- Each digit is held exactly SCAN_DIV cycles. One frame is 8·SCAN_DIV cycles.
- The shadow load and `idx` 7→0 occur on the same edge. The first digit shown after it already uses new data; no tearing.
- `rst` mid-frame: on the next edge all state returns to reset values and the partial frame is discarded. The first full frame after reset shows 00-00-00.
- Inputs are sampled only at the frame wrap. They need no synchronisation beyond being in the `clk` domain.

## Structure
- Package `clock_display_pkg` holds:
  - segment constants: SEG_0..SEG_9, SEG_E=86, SEG_DASH=BF, SEG_BLANK=FF;
  - digit-index constants: IDX_SEC_ONES..IDX_HOUR_TENS, SEP_IDX_A=2, SEP_IDX_B=5.
- Sub-module `seg7_decode` is a combinational 4-bit nibble → 8-bit active-low segment decoder, including the 'E' fallback. Instantiate it once on the muxed nibble.
- The top holds the prescaler, index counter, shadow register, digit mux, separator/LZB override, and output registers.

## Test plan
Run with SCAN_DIV=4, LZB=1.
- **Reset:** hold `rst` 3 cycles → `an`=FF, `seg`=FF. After release, cycle 1 is FF/FF and cycle 2 is FE/C0. `frame_start` is high in cycle 1.
- **Normal frame:** inputs 23:59:58 held across a wrap → the next frame is:
  - `an` FE→FD→FB→F7→EF→DF→BF→7F, each for 4 cycles;
  - `seg` 80, 92, BF, 90, 92, BF, B0, A4.
- **Odd second / LZB:** inputs 05:07:09 → separators FF; digit 7 FF; digit 6 92. With LZB=0, digit 7 is C0.
- **Snapshot:** change `second` 0x10→0x11 while `idx`=3 → the remaining digits of that frame keep the old value; digit 0 of the next frame shows F9.
- **Invalid BCD:** `second`=0x3C → digit 0 `seg`=86, digit 1 `seg`=B0.
- **Mid-frame reset:** pulse `rst` 1 cycle at `idx`=5 → next cycle `an`=FF. Then `an`=FE, `seg`=C0 for 4 cycles, and the whole first frame shows 00-00-00 with dashes.
